// File: rtl/grf_dump_reader.sv
// grf_dump_reader: walks register file indices FIRST_REG..LAST_REG through a
// dedicated read port and streams each register out as an (index, data) beat
// on a valid/ready interface, followed by a one-cycle done pulse.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          asynchronous active-low reset
//   start          request a dump (sampled only while idle)
//   abort          cancel a dump in progress (sampled in every state)
//   grfReadAddress register-file read address (idx while reading/holding, else 0)
//   grfReadData    combinational register-file read data for grfReadAddress
//   outValid       beat available
//   outReady       consumer accepts the beat
//   outIndex       register index of the beat
//   outData        register value of the beat
//   outLast        beat is LAST_REG
//   busy           dump in progress
//   done           one-cycle pulse after the last beat is accepted
module grf_dump_reader #(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   output logic [4:0]  grfReadAddress,
   input  logic [31:0] grfReadData,
   output logic        outValid,
   input  logic        outReady,
   output logic [4:0]  outIndex,
   output logic [31:0] outData,
   output logic        outLast,
   output logic        busy,
   output logic        done
);

   localparam int unsigned IDX_W  = 5;
   localparam int unsigned DATA_W = 32;

   localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    addr_q, addr_d;
   logic                valid_q, valid_d;
   logic [IDX_W-1:0]    index_q, index_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                last_q, last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // Next-state and next-output logic; read address and busy are computed
   // from the next state so they are registered yet aligned with the state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      valid_d = valid_q;
      index_d = index_q;
      data_d  = data_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // abort takes priority over a simultaneous start
            if (start && !abort) begin
               state_d = S_READ;
               idx_d   = FIRST_IDX;
               addr_d  = FIRST_IDX;
               busy_d  = 1'b1;
            end
         end

         S_READ: begin
            if (abort) begin
               state_d = S_IDLE;
               addr_d  = '0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else begin
               // Capture the read port value seen this cycle; a write landing
               // on this same edge is therefore not part of the beat.
               data_d  = grfReadData;
               index_d = idx_q;
               last_d  = (idx_q == LAST_IDX);
               valid_d = 1'b1;
               state_d = S_HOLD;
            end
         end

         S_HOLD: begin
            if (abort) begin
               state_d = S_IDLE;
               addr_d  = '0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else if (outReady) begin
               valid_d = 1'b0;
               if (last_q) begin
                  state_d = S_DONE;
                  addr_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  // idx stops at LAST_REG, so this increment never wraps
                  idx_d   = idx_q + IDX_W'(1);
                  addr_d  = idx_q + IDX_W'(1);
                  state_d = S_READ;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            addr_d  = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         index_q <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
         index_q <= index_d;
         data_q  <= data_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign grfReadAddress = addr_q;
   assign outValid       = valid_q;
   assign outIndex       = index_q;
   assign outData        = data_q;
   assign outLast        = last_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule

// File: tb/tb_grf_dump_reader.sv
// Testbench for grf_dump_reader: a full-range instance driven by randomized
// dumps against an arithmetic timeline model, and a single-register instance
// driven from a per-cycle vector table.
module tb_grf_dump_reader;

   localparam int N = 32;

   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   // register file model shared by both instances
   logic [31:0] rf [32];
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

   // full-range instance
   logic        a_start, a_abort, a_ready;
   logic [4:0]  a_addr, a_index;
   logic [31:0] a_rdata, a_data;
   logic        a_valid, a_last, a_busy, a_done;
   assign a_rdata = rf[a_addr];

   grf_dump_reader u_dut_a (
      .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
      .grfReadAddress(a_addr), .grfReadData(a_rdata),
      .outValid(a_valid), .outReady(a_ready), .outIndex(a_index),
      .outData(a_data), .outLast(a_last), .busy(a_busy), .done(a_done)
   );

   // single-register instance
   logic        b_start, b_abort, b_ready;
   logic [4:0]  b_addr, b_index;
   logic [31:0] b_rdata, b_data;
   logic        b_valid, b_last, b_busy, b_done;
   assign b_rdata = rf[b_addr];

   grf_dump_reader #(.FIRST_REG(8), .LAST_REG(8)) u_dut_b (
      .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
      .grfReadAddress(b_addr), .grfReadData(b_rdata),
      .outValid(b_valid), .outReady(b_ready), .outIndex(b_index),
      .outData(b_data), .outLast(b_last), .busy(b_busy), .done(b_done)
   );

   int vecs = 0;
   int miscmp = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic chk_all_reset(input string tag);
      chk({tag, " a_addr"},  32'(a_addr),  32'd0);
      chk({tag, " a_valid"}, 32'(a_valid), 32'd0);
      chk({tag, " a_index"}, 32'(a_index), 32'd0);
      chk({tag, " a_data"},  a_data,       32'd0);
      chk({tag, " a_last"},  32'(a_last),  32'd0);
      chk({tag, " a_busy"},  32'(a_busy),  32'd0);
      chk({tag, " a_done"},  32'(a_done),  32'd0);
      chk({tag, " b_valid"}, 32'(b_valid), 32'd0);
      chk({tag, " b_busy"},  32'(b_busy),  32'd0);
   endtask

   // One dump on instance a. Beat k becomes valid at sample t[k], is held for
   // s[k] stall cycles, and is accepted on the following edge; the next beat
   // is valid two samples later. done appears at sample 2N + sum(s).
   // mode: 0 no stalls, 1 stall sl cycles on beat sb, 2 random stalls.
   // ab_beat >= 0 aborts in the hold of that beat; pulse_c >= 0 pulses start
   // mid-dump; wb >= 0 writes wv to register wb on the edge ending its read.
   task automatic run_dump(input int mode, input int sb, input int sl,
                           input int ab_beat, input int pulse_c,
                           input int wb, input logic [31:0] wv);
      int          s [N];
      int          t [N];
      logic [31:0] snap [32];
      logic        ev [256];
      logic [4:0]  ei [256];
      logic [4:0]  ea [256];
      int          total, last_c, ta;
      for (int k = 0; k < N; k++) begin
         if (mode == 2)                 s[k] = int'($urandom_range(0, 3));
         else if (mode == 1 && k == sb) s[k] = sl;
         else                           s[k] = 0;
      end
      t[0] = 1;
      for (int k = 1; k < N; k++) t[k] = t[k-1] + s[k-1] + 2;
      total = t[N-1] + s[N-1] + 1;
      for (int c = 0; c < 256; c++) begin
         ev[c] = 1'b0; ei[c] = 5'd0; ea[c] = 5'd0;
      end
      for (int k = 0; k < N; k++) begin
         ea[t[k]-1] = 5'(k);
         for (int d = 0; d <= s[k]; d++) begin
            ev[t[k]+d] = 1'b1;
            ei[t[k]+d] = 5'(k);
            ea[t[k]+d] = 5'(k);
         end
      end
      for (int r = 0; r < 32; r++) snap[r] = rf[r];
      ta     = (ab_beat >= 0) ? t[ab_beat] : -1;
      last_c = (ta >= 0) ? ta + 4 : total + 1;

      a_start = 1'b1; a_abort = 1'b0; a_ready = 1'($urandom);
      for (int c = 0; c <= last_c; c++) begin
         @(negedge clk);
         a_start = 1'b0; a_abort = 1'b0; wr_en = 1'b0;
         if (ta >= 0 && c > ta) begin
            chk($sformatf("abort valid c=%0d", c), 32'(a_valid), 32'd0);
            chk($sformatf("abort busy c=%0d", c),  32'(a_busy),  32'd0);
            chk($sformatf("abort done c=%0d", c),  32'(a_done),  32'd0);
            chk($sformatf("abort addr c=%0d", c),  32'(a_addr),  32'd0);
         end else begin
            chk($sformatf("valid c=%0d", c), 32'(a_valid), 32'(ev[c]));
            chk($sformatf("addr c=%0d", c),  32'(a_addr),  32'(ea[c]));
            chk($sformatf("busy c=%0d", c),  32'(a_busy),  32'(c <= total));
            chk($sformatf("done c=%0d", c),  32'(a_done),  32'(c == total));
            if (ev[c]) begin
               chk($sformatf("index c=%0d", c), 32'(a_index), 32'(ei[c]));
               chk($sformatf("data c=%0d", c),  a_data,       snap[ei[c]]);
               chk($sformatf("last c=%0d", c),  32'(a_last),  32'(ei[c] == 5'd31));
            end
         end
         a_start = (c == pulse_c);
         a_ready = ev[c] ? !ev[c+1] : 1'($urandom);
         if (c == ta) begin
            a_abort = 1'b1;
            a_ready = 1'b0;
         end
         if (wb >= 0 && c == t[wb] - 1) begin
            wr_en = 1'b1; wr_addr = 5'(wb); wr_data = wv;
         end
      end
      a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b0; wr_en = 1'b0;
   endtask

   typedef struct {
      logic       st, ab, rd;
      logic       ev, el, eb, ed;
      logic [4:0] ea;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic ab, input logic rd,
                               input logic ev, input logic el, input logic eb,
                               input logic ed, input logic [4:0] ea);
      vec_t v;
      v.st = st; v.ab = ab; v.rd = rd;
      v.ev = ev; v.el = el; v.eb = eb; v.ed = ed; v.ea = ea;
      return v;
   endfunction

   vec_t tbl [22];

   initial begin
      //           st    ab    rd    ev    el    eb    ed    ea
      tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8); // read
      tbl[1]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8); // hold
      tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0); // done
      tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); // idle
      tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); // start+abort
      tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8);
      tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
      tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8); // stall
      tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); // abort hold
      tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8);
      tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
      tbl[11] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); // abort beats ready
      tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8);
      tbl[13] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
      tbl[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
      tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); // abort in done
      tbl[16] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8);
      tbl[17] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8); // start ignored
      tbl[18] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
      tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); // done start ignored
      tbl[20] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8);
      tbl[21] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); // abort in read

      a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b0;
      b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
      wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #1 chk_all_reset("por");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      for (int r = 0; r < 32; r++)
         write_reg(5'(r), (r == 0) ? 32'd0 : 32'h1000_0000 + 32'(r));

      // asynchronous reset while a beat is held
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0; a_ready = 1'b0;
      @(negedge clk);
      chk("pre-reset valid", 32'(a_valid), 32'd1);
      #2 reset = 1'b0;
      #1 chk_all_reset("async");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("post-reset busy %0d", i), 32'(a_busy), 32'd0);
         chk($sformatf("post-reset valid %0d", i), 32'(a_valid), 32'd0);
      end

      run_dump(0, 0, 0, -1, -1, -1, 32'd0);             // full dump, 64 cycles
      run_dump(1, 3, 5, -1, -1, -1, 32'd0);             // 5 stall cycles on beat 3
      run_dump(0, 0, 0,  7, -1, -1, 32'd0);             // abort in hold of beat 7
      run_dump(2, 0, 0, -1, 20, 5, 32'hDEAD_BEEF);      // restart, ignored start, coherency
      run_dump(0, 0, 0, -1, -1, -1, 32'd0);             // shows the new register 5 value
      chk("r5 written", rf[5], 32'hDEAD_BEEF);

      for (int n = 0; n < 4; n++) begin
         for (int w = 0; w < 4; w++)
            write_reg(5'($urandom_range(0, 31)), $urandom);
         run_dump(2, 0, 0, -1, -1, -1, 32'd0);
      end

      for (int i = 0; i < 22; i++) begin
         b_start = tbl[i].st; b_abort = tbl[i].ab; b_ready = tbl[i].rd;
         @(negedge clk);
         chk($sformatf("b valid v%0d", i), 32'(b_valid), 32'(tbl[i].ev));
         chk($sformatf("b busy v%0d", i),  32'(b_busy),  32'(tbl[i].eb));
         chk($sformatf("b done v%0d", i),  32'(b_done),  32'(tbl[i].ed));
         chk($sformatf("b addr v%0d", i),  32'(b_addr),  32'(tbl[i].ea));
         if (tbl[i].ev) begin
            chk($sformatf("b index v%0d", i), 32'(b_index), 32'd8);
            chk($sformatf("b data v%0d", i),  b_data,       rf[8]);
            chk($sformatf("b last v%0d", i),  32'(b_last),  32'(tbl[i].el));
         end
      end
      b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule

// File: doc/grf_dump_reader.md
# grf_dump_reader

Debug/trace block that walks the general register file through one of its read ports and streams every register out as an (index, data) beat on a valid/ready interface. It sits beside the register file, shares its clock, and drives a dedicated read address in place of the decode stage's read port. It is used for end-of-test register dumps and for on-demand snapshots by the trace logic.

## Interface
Parameters:
- `FIRST_REG`, default 0: first register index dumped.
- `LAST_REG`, default 31: last register index dumped. `FIRST_REG <= LAST_REG <= 31` is required.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting it (low) clears all state immediately, independent of `clk`.
- `start`  in  1  request a dump; sampled only in IDLE.
- `abort`  in  1  cancel the dump in progress; sampled in every state.
- `grfReadAddress`  out  5  register-file read address.
- `grfReadData`  in  32  combinational read data for `grfReadAddress`.
- `outValid`  out  1  beat available.
- `outReady`  in  1  consumer accepts the beat.
- `outIndex`  out  5  register index of the beat.
- `outData`  out  32  register value of the beat.
- `outLast`  out  1  beat is `LAST_REG`.
- `busy`  out  1  high in READ, HOLD and DONE.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Internal state: index counter `idx` (5 bits) and an FSM with states IDLE, READ, HOLD and DONE.
- Reset values: state IDLE, `idx`=0, `grfReadAddress`=0, `outValid`=0, `outIndex`=0, `outData`=0, `outLast`=0, `busy`=0, `done`=0.
- `grfReadAddress` equals `idx` in READ and HOLD, and 0 otherwise.
- IDLE:
  - On `start` with `abort` low: `idx` <= `FIRST_REG`, go to READ.
  - `start` and `abort` high together: `abort` wins and the block stays in IDLE.
- READ (1 cycle):
  - Register the beat: `outData` <= `grfReadData`, `outIndex` <= `idx`, `outLast` <= (`idx`==`LAST_REG`), `outValid` <= 1.
  - Go to HOLD.
- HOLD:
  - The beat is held with `outValid`, `outIndex`, `outData` and `outLast` stable until `outReady`=1 at a clock edge.
  - On acceptance, `outValid` <= 0.
  - If `outLast`, go to DONE. Otherwise `idx` <= `idx`+1 and go to READ.
  - `idx` never wraps, because the walk stops at `LAST_REG`.
- DONE (1 cycle): `done`=1, then go to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `abort` in READ, HOLD or DONE: next state is IDLE and `outValid` <= 0. In DONE, `done` is still driven for that cycle.
  - Dropping `outValid` on abort is the single permitted exception to the hold-until-accepted rule.
  - An aborted dump never pulses `done`.
- Coherency: each beat carries the register value visible on the read port during its READ cycle.
  - A register-file write committing at the same edge is not included; the old value is captured.
  - Later writes do not alter a beat that is already registered.

## Timing
- `start` is sampled at edge E0. The first beat is valid after E1 (latency 1 cycle from the sampling edge).
- With `outReady` held at 1, beats are accepted at E2, E4, …, so throughput is 1 beat per 2 cycles.
- With N = `LAST_REG`−`FIRST_REG`+1 beats:
  - the last beat is accepted at E(2N);
  - `done` is high for the cycle following E(2N);
  - `busy` falls after E(2N+1).
- Each cycle of `outReady`=0 in HOLD adds exactly 1 cycle.
- `busy` rises the cycle after the sampling edge and stays high until the return to IDLE.
- When `reset` goes low, all outputs take their reset values within the same cycle, before the next edge. The first `start` is sampled at the first edge after `reset` returns high.

## Test plan
- Reset: drive `reset` low mid-HOLD, with `outValid`=1, before any clock edge → every output reads its reset value immediately; after release, with `start`=0, the block stays idle (`busy`=0).
- Full dump with defaults and `outReady`=1, register r preloaded with 0x1000_0000+r (register 0 reads 0) → 32 beats with `outIndex` 0..31 and matching `outData`; `outLast` only on index 31; `done` pulses once, 1 cycle after the 32nd acceptance; 64 cycles from the sampling edge to the `done` cycle.
- Backpressure: `outReady` low for 5 cycles on beat index 3 → index 3 and its data stay stable across all 5 cycles with `outValid` high; total dump time grows by exactly 5 cycles.
- Abort: assert `abort` in HOLD of index 7 → `outValid` low after the next edge, `busy` falls, no `done`; a new `start` then restarts from index 0.
- Ignored start and coherency: pulse `start` during the dump → exactly one dump. Write register 5 with 0xDEADBEEF at the edge ending READ of index 5 → the beat shows the old value; a second dump shows 0xDEADBEEF.
- Parameters `FIRST_REG`=8, `LAST_REG`=8 → exactly one beat, index 8, with `outLast`=1, then `done`.
